// File: rtl/dp_pkg.sv
// Shared encodings and default width for the execution datapath.
// Constants only; no logic, so no latency or backpressure applies.
package dp_pkg;

  localparam int DATA_W = 8;

  localparam logic [1:0] MUX_ALU = 2'b00;
  localparam logic [1:0] MUX_RF  = 2'b01;
  localparam logic [1:0] MUX_IN  = 2'b10;
  localparam logic [1:0] MUX_MEM = 2'b11;

  localparam logic [2:0] ALU_A   = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_NOT = 3'b101;
  localparam logic [2:0] ALU_INC = 3'b110;
  localparam logic [2:0] ALU_DEC = 3'b111;

  localparam logic [1:0] SH_PASS = 2'b00;
  localparam logic [1:0] SH_SHL  = 2'b01;
  localparam logic [1:0] SH_SHR  = 2'b10;
  localparam logic [1:0] SH_ROR  = 2'b11;

endpackage

// File: rtl/dp_alu_shift.sv
// ALU followed by shifter on the ALU result; purely combinational, zero latency.
// No handshake: result tracks inputs within the same cycle, no backpressure.
module dp_alu_shift #(
  parameter int DATA_W = dp_pkg::DATA_W
) (
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] r,
  input  logic [2:0]        alusel,
  input  logic [1:0]        shiftsel,
  output logic [DATA_W-1:0] result
);
  import dp_pkg::*;

  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

  logic [DATA_W-1:0] alu;

  // Sums are truncated to DATA_W, so carry and borrow simply fall off.
  always_comb begin
    alu = acc;
    case (alusel)
      ALU_A:   alu = acc;
      ALU_ADD: alu = acc + r;
      ALU_SUB: alu = acc - r;
      ALU_AND: alu = acc & r;
      ALU_OR:  alu = acc | r;
      ALU_NOT: alu = ~acc;
      ALU_INC: alu = acc + ONE;
      ALU_DEC: alu = acc - ONE;
      default: alu = acc;
    endcase
  end

  always_comb begin
    result = alu;
    case (shiftsel)
      SH_PASS: result = alu;
      SH_SHL:  result = {alu[DATA_W-2:0], 1'b0};
      SH_SHR:  result = {1'b0, alu[DATA_W-1:1]};
      SH_ROR:  result = {alu[0], alu[DATA_W-1:1]};
      default: result = alu;
    endcase
  end

endmodule

// File: rtl/exec_datapath.sv
// Accumulator datapath with RF, optional data memory (DP_DATA_MEM_EN), output reg; writes land 1 edge after enables.
// No backpressure: the controller owns sequencing; flags are combinational from ACC.
module exec_datapath #(
  parameter int DATA_W    = dp_pkg::DATA_W,
  parameter int RF_DEPTH  = 8,
  parameter int MEM_DEPTH = 16
) (
  input  logic                         clk_dp,
  input  logic                         rst_dp,
  input  logic [1:0]                   muxsel_dp,
  input  logic [DATA_W-1:0]            imm_dp,
  input  logic [DATA_W-1:0]            input_dp,
  input  logic                         accwr_dp,
  input  logic [$clog2(RF_DEPTH)-1:0]  rfaddr_dp,
  input  logic                         rfwr_dp,
  input  logic [$clog2(MEM_DEPTH)-1:0] mmadr_dp,
  input  logic                         mmwr_dp,
  input  logic [2:0]                   alusel_dp,
  input  logic [1:0]                   shiftsel_dp,
  input  logic                         outen_dp,
  output logic                         zero_dp,
  output logic                         positive_dp,
  output logic [DATA_W-1:0]            output_dp
);
  import dp_pkg::*;

  logic              rst_sync_n;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] acc_next;
  logic [DATA_W-1:0] rf [RF_DEPTH];
  logic [DATA_W-1:0] rf_rd;
  logic [DATA_W-1:0] mem_rd;
  logic [DATA_W-1:0] alu_res;

  // Assertion is immediate; release is held off until the next clock edge.
  always_ff @(posedge clk_dp or negedge rst_dp) begin
    if (!rst_dp) rst_sync_n <= 1'b0;
    else         rst_sync_n <= 1'b1;
  end

  assign rf_rd = rf[rfaddr_dp];

  dp_alu_shift #(.DATA_W(DATA_W)) u_alu_shift (
    .acc      (acc),
    .r        (rf_rd),
    .alusel   (alusel_dp),
    .shiftsel (shiftsel_dp),
    .result   (alu_res)
  );

`ifdef DP_DATA_MEM_EN
  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic              unused_in;

  assign unused_in = ^imm_dp;
  assign mem_rd    = mem[mmadr_dp];

  always_ff @(posedge clk_dp or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (mmwr_dp) begin
      mem[mmadr_dp] <= acc;
    end
  end
`else
  logic unused_in;

  assign unused_in = ^{imm_dp, mmadr_dp, mmwr_dp};
  assign mem_rd    = '0;
`endif

  always_comb begin
    acc_next = alu_res;
    case (muxsel_dp)
      MUX_ALU: acc_next = alu_res;
      MUX_RF:  acc_next = rf_rd;
      MUX_IN:  acc_next = input_dp;
      MUX_MEM: acc_next = mem_rd;
      default: acc_next = alu_res;
    endcase
  end

  // All stores sample the pre-edge ACC, so RF/MEM/ACC updates never bypass each other.
  always_ff @(posedge clk_dp or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      acc       <= '0;
      output_dp <= '0;
      for (int i = 0; i < RF_DEPTH; i++) rf[i] <= '0;
    end else begin
      if (accwr_dp) acc           <= acc_next;
      if (outen_dp) output_dp     <= acc;
      if (rfwr_dp)  rf[rfaddr_dp] <= acc;
    end
  end

  assign zero_dp     = (acc == '0);
  assign positive_dp = ~acc[DATA_W-1] & (acc != '0);

endmodule

// File: tb/tb_exec_datapath.sv
// Directed bench for exec_datapath; ACC is observed through output_dp and the flags.
module tb_exec_datapath;
  import dp_pkg::*;

  logic       clk_dp      = 1'b0;
  logic       rst_dp      = 1'b0;
  logic [1:0] muxsel_dp   = '0;
  logic [7:0] imm_dp      = '0;
  logic [7:0] input_dp    = '0;
  logic       accwr_dp    = 1'b0;
  logic [2:0] rfaddr_dp   = '0;
  logic       rfwr_dp     = 1'b0;
  logic [3:0] mmadr_dp    = '0;
  logic       mmwr_dp     = 1'b0;
  logic [2:0] alusel_dp   = '0;
  logic [1:0] shiftsel_dp = '0;
  logic       outen_dp    = 1'b0;
  logic       zero_dp;
  logic       positive_dp;
  logic [7:0] output_dp;

  int n_chk  = 0;
  int n_fail = 0;

  exec_datapath dut (
    .clk_dp      (clk_dp),
    .rst_dp      (rst_dp),
    .muxsel_dp   (muxsel_dp),
    .imm_dp      (imm_dp),
    .input_dp    (input_dp),
    .accwr_dp    (accwr_dp),
    .rfaddr_dp   (rfaddr_dp),
    .rfwr_dp     (rfwr_dp),
    .mmadr_dp    (mmadr_dp),
    .mmwr_dp     (mmwr_dp),
    .alusel_dp   (alusel_dp),
    .shiftsel_dp (shiftsel_dp),
    .outen_dp    (outen_dp),
    .zero_dp     (zero_dp),
    .positive_dp (positive_dp),
    .output_dp   (output_dp)
  );

  always #5 clk_dp = ~clk_dp;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge and are sampled there too.
  task automatic step();
    @(posedge clk_dp);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    muxsel_dp = MUX_IN; input_dp = v; accwr_dp = 1'b1;
    step();
    accwr_dp = 1'b0;
  endtask

  task automatic alu(input logic [2:0] op, input logic [1:0] sh, input logic [2:0] ra);
    muxsel_dp = MUX_ALU; alusel_dp = op; shiftsel_dp = sh; rfaddr_dp = ra; accwr_dp = 1'b1;
    step();
    accwr_dp = 1'b0; alusel_dp = ALU_A; shiftsel_dp = SH_PASS;
  endtask

  task automatic show(input string tag, input logic [7:0] exp);
    outen_dp = 1'b1;
    step();
    outen_dp = 1'b0;
    chk(tag, output_dp, exp);
  endtask

  task automatic flags(input string tag, input logic z, input logic p);
    chk({tag, "_zero"}, {7'b0, zero_dp}, {7'b0, z});
    chk({tag, "_pos"},  {7'b0, positive_dp}, {7'b0, p});
  endtask

  logic [7:0] mem_exp;

  initial begin
`ifdef DP_DATA_MEM_EN
    mem_exp = 8'h3C;
`else
    mem_exp = 8'h00;
`endif
    #1;
    flags("reset", 1'b1, 1'b0);
    chk("reset_out", output_dp, 8'h00);
    step();
    step();

    // Release mid-cycle: the following edge must still be held in reset.
    rst_dp = 1'b1;
    muxsel_dp = MUX_IN; input_dp = 8'h22; accwr_dp = 1'b1;
    step();
    accwr_dp = 1'b0;
    flags("release_edge", 1'b1, 1'b0);

    load(8'h05);
    flags("load05", 1'b0, 1'b1);
    show("acc05", 8'h05);

    rfaddr_dp = 3'd3; rfwr_dp = 1'b1;
    step();
    rfwr_dp = 1'b0;
    load(8'hFE);
    flags("loadFE", 1'b0, 1'b0);
    alu(ALU_ADD, SH_PASS, 3'd3);
    show("add_wrap", 8'h03);
    alu(ALU_DEC, SH_PASS, 3'd0);
    alu(ALU_DEC, SH_PASS, 3'd0);
    alu(ALU_DEC, SH_PASS, 3'd0);
    flags("dec_to_zero", 1'b1, 1'b0);
    alu(ALU_DEC, SH_PASS, 3'd0);
    show("dec_underflow", 8'hFF);
    alu(ALU_INC, SH_PASS, 3'd0);
    flags("inc_overflow", 1'b1, 1'b0);

    load(8'h10);
    alu(ALU_SUB, SH_PASS, 3'd3);
    show("sub", 8'h0B);
    alu(ALU_AND, SH_PASS, 3'd3);
    show("and", 8'h01);
    load(8'h0A);
    alu(ALU_OR, SH_PASS, 3'd3);
    show("or", 8'h0F);
    alu(ALU_NOT, SH_PASS, 3'd3);
    show("not", 8'hF0);

    load(8'h81);
    alu(ALU_A, SH_ROR, 3'd0);
    show("ror", 8'hC0);
    alu(ALU_A, SH_SHL, 3'd0);
    flags("shl", 1'b0, 1'b0);
    show("shl", 8'h80);
    alu(ALU_A, SH_SHR, 3'd0);
    flags("shr", 1'b0, 1'b1);
    show("shr", 8'h40);
    alu(ALU_INC, SH_SHL, 3'd0);
    show("inc_then_shl", 8'h82);

    load(8'h3C);
    muxsel_dp = MUX_MEM; mmadr_dp = 4'd9; mmwr_dp = 1'b1; accwr_dp = 1'b1;
    step();
    mmwr_dp = 1'b0; accwr_dp = 1'b0;
    flags("mem_swap", 1'b1, 1'b0);
    muxsel_dp = MUX_MEM; mmadr_dp = 4'd9; accwr_dp = 1'b1;
    step();
    accwr_dp = 1'b0;
    show("mem_readback", mem_exp);

    load(8'h77);
    muxsel_dp = MUX_RF; rfaddr_dp = 3'd5; rfwr_dp = 1'b1; accwr_dp = 1'b1;
    step();
    rfwr_dp = 1'b0; accwr_dp = 1'b0;
    show("rf_old_read", 8'h00);
    muxsel_dp = MUX_RF; rfaddr_dp = 3'd5; accwr_dp = 1'b1;
    step();
    accwr_dp = 1'b0;
    show("rf_new_read", 8'h77);

    load(8'hA5);
    show("outen", 8'hA5);
    load(8'h11);
    step();
    chk("out_hold", output_dp, 8'hA5);
    flags("acc11", 1'b0, 1'b1);

    // Reset lands mid-cycle with a register write pending.
    rfaddr_dp = 3'd6; rfwr_dp = 1'b1;
    rst_dp = 1'b0;
    #1;
    chk("rst_out_now", output_dp, 8'h00);
    flags("rst_now", 1'b1, 1'b0);
    step();
    rst_dp = 1'b1;
    rfwr_dp = 1'b0;
    step();
    load(8'h55);
    muxsel_dp = MUX_RF; rfaddr_dp = 3'd6; accwr_dp = 1'b1;
    step();
    accwr_dp = 1'b0;
    show("rst_rf6", 8'h00);
    muxsel_dp = MUX_RF; rfaddr_dp = 3'd3; accwr_dp = 1'b1;
    step();
    accwr_dp = 1'b0;
    show("rst_rf3", 8'h00);
    muxsel_dp = MUX_MEM; mmadr_dp = 4'd9; accwr_dp = 1'b1;
    step();
    accwr_dp = 1'b0;
    show("rst_mem9", 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
